slot_playback_fifo: RTL and testbench



---
 rtl/slot_playback_fifo.sv | 101 ++++++++++
 tb/tb_slot_playback_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/slot_playback_fifo.sv
// Byte FIFO feeding a slot's DAC serializer.
// Wrap-bit pointers, registered read port, lifetime byte counters.
module slot_playback_fifo #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [ADDR_WIDTH:0]   level,
   output logic [31:0]           write_byte_count,
   output logic [31:0]           read_byte_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LP_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LP_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [31:0]           r_wr_cnt;
   logic [31:0]           r_rd_cnt;
   logic                  r_ovf;
   logic                  r_unf;

   logic [ADDR_WIDTH:0]   w_level;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   assign w_level  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_level == LP_FULL);
   assign w_empty  = (w_level == '0);
   // full/empty are sampled from current state, so a read never
   // makes room for a same-cycle write and a write never falls through
   assign w_wr_acc = wr_en & ~w_full & ~clear & ~reset;
   assign w_rd_acc = rd_en & ~w_empty;

   assign full             = w_full;
   assign empty            = w_empty;
   assign level            = w_level;
   assign addr_in          = r_wr_ptr[ADDR_WIDTH-1:0];
   assign addr_out         = r_rd_ptr[ADDR_WIDTH-1:0];
   assign rd_data          = r_rd_data;
   assign write_byte_count = r_wr_cnt;
   assign read_byte_count  = r_rd_cnt;
   assign overflow         = r_ovf;
   assign underflow        = r_unf;

   // storage write port, no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[addr_in] <= wr_data;
   end

   // pointers, read register, counters and error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else if (clear) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         r_ovf <= wr_en & w_full;
         r_unf <= rd_en & w_empty;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + LP_ONE;
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
         if (w_rd_acc) begin
            r_rd_data <= r_mem[addr_out];
            r_rd_ptr  <= r_rd_ptr + LP_ONE;
            r_rd_cnt  <= r_rd_cnt + 32'd1;
         end else if (rd_en) begin
            r_rd_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_slot_playback_fifo.sv
// Directed bench for slot_playback_fifo.
// Hand-computed expectations for fill, drain, wrap, clear, errors.
module tb_slot_playback_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        full;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_data;
   logic        empty;
   logic [10:0] addr_in;
   logic [10:0] addr_out;
   logic [11:0] level;
   logic [31:0] write_byte_count;
   logic [31:0] read_byte_count;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   slot_playback_fifo dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .wr_en            (wr_en),
      .wr_data          (wr_data),
      .full             (full),
      .rd_en            (rd_en),
      .rd_data          (rd_data),
      .empty            (empty),
      .addr_in          (addr_in),
      .addr_out         (addr_out),
      .level            (level),
      .write_byte_count (write_byte_count),
      .read_byte_count  (read_byte_count),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 3) + 1);
   endfunction

   initial begin
      // reset state
      tick();
      do_reset();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ain", 32'(addr_in), 32'd0);
      chk("rst_aout", 32'(addr_out), 32'd0);
      chk("rst_rdata", 32'(rd_data), 32'd0);
      chk("rst_wcnt", write_byte_count, 32'd0);
      chk("rst_rcnt", read_byte_count, 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_unf", 32'(underflow), 32'd0);

      // four bytes in, four back-to-back reads out
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(8'h10 + i);
         tick();
      end
      wr_en = 1'b0;
      chk("w4_level", 32'(level), 32'd4);
      chk("w4_wcnt", write_byte_count, 32'd4);
      chk("w4_empty", 32'(empty), 32'd0);
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("r4_data", 32'(rd_data), 32'(8'h10 + i));
         chk("r4_level", 32'(level), 32'(3 - i));
      end
      rd_en = 1'b0;
      chk("r4_empty", 32'(empty), 32'd1);
      chk("r4_rcnt", read_byte_count, 32'd4);
      chk("r4_unf", 32'(underflow), 32'd0);
      tick();
      chk("hold_rdata", 32'(rd_data), 32'h13);

      // underflow on empty FIFO
      do_reset();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("unf_pulse", 32'(underflow), 32'd1);
      chk("unf_rdata", 32'(rd_data), 32'd0);
      chk("unf_aout", 32'(addr_out), 32'd0);
      chk("unf_rcnt", read_byte_count, 32'd0);
      tick();
      chk("unf_clr", 32'(underflow), 32'd0);

      // fill to full, then one rejected write
      do_reset();
      for (int i = 0; i < 2048; i++) begin
         wr_en = 1'b1;
         wr_data = pat(i);
         tick();
      end
      chk("full_flag", 32'(full), 32'd1);
      chk("full_level", 32'(level), 32'd2048);
      chk("full_ain", 32'(addr_in), 32'd0);
      chk("full_wcnt", write_byte_count, 32'd2048);
      chk("full_ovf0", 32'(overflow), 32'd0);
      wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_wcnt", write_byte_count, 32'd2048);
      chk("ovf_level", 32'(level), 32'd2048);
      tick();
      chk("ovf_clr", 32'(overflow), 32'd0);

      // full: simultaneous read accepted, write rejected
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("fs_ovf", 32'(overflow), 32'd1);
      chk("fs_rdata", 32'(rd_data), 32'(pat(0)));
      chk("fs_level", 32'(level), 32'd2047);
      chk("fs_aout", 32'(addr_out), 32'd1);
      chk("fs_rcnt", read_byte_count, 32'd1);
      chk("fs_wcnt", write_byte_count, 32'd2048);

      // 2047 stored, 10 simultaneous cycles across the write wrap
      do_reset();
      for (int i = 0; i < 2047; i++) begin
         wr_en = 1'b1;
         wr_data = pat(i);
         tick();
      end
      wr_en = 1'b0;
      chk("f7_level", 32'(level), 32'd2047);
      chk("f7_ain", 32'(addr_in), 32'd2047);
      for (int k = 0; k < 10; k++) begin
         wr_en = 1'b1;
         rd_en = 1'b1;
         wr_data = 8'(8'hC0 + k);
         tick();
         chk("sim_data", 32'(rd_data), 32'(pat(k)));
         chk("sim_level", 32'(level), 32'd2047);
      end
      wr_en = 1'b0;
      chk("sim_ain", 32'(addr_in), 32'd9);
      chk("sim_aout", 32'(addr_out), 32'd10);
      chk("sim_ovf", 32'(overflow), 32'd0);
      for (int k = 10; k < 2047; k++) begin
         tick();
         chk("drain_old", 32'(rd_data), 32'(pat(k)));
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("drain_wrap", 32'(rd_data), 32'(8'hC0 + k));
      end
      rd_en = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_aout", 32'(addr_out), 32'd9);
      chk("drain_rcnt", read_byte_count, 32'd2057);
      chk("drain_wcnt", write_byte_count, 32'd2057);

      // clear flushes contents but keeps counts
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(8'h21 + i);
         tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("pc_rdata", 32'(rd_data), 32'h21);
      clear = 1'b1;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      clear = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("clr_level", 32'(level), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_ain", 32'(addr_in), 32'd0);
      chk("clr_aout", 32'(addr_out), 32'd0);
      chk("clr_rdata", 32'(rd_data), 32'd0);
      chk("clr_wcnt", write_byte_count, 32'd5);
      chk("clr_rcnt", read_byte_count, 32'd1);
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_unf", 32'(underflow), 32'd0);
      do_reset();
      chk("rst2_wcnt", write_byte_count, 32'd0);
      chk("rst2_rcnt", read_byte_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
